iterative_shifter: RTL

- Multi-cycle operand-2 shift unit for the datapath. Covers all four shift types: LSL, LSR, ASR and ROR.
- Shifts one bit per clock under a start/busy/done handshake and produces the shifter carry-out.
- Sits beside the combinational operand-2 path. The control unit steers register-specified and arithmetic/rotate shifts here and stalls on busy.

---
 rtl/iterative_shifter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/iterative_shifter.sv
// rtl/iterative_shifter.sv - one-bit-per-cycle LSL/LSR/ASR/ROR operand-2 shifter
// Start/busy/done handshake; result and carry_out are registered and held until the next start.
module iterative_shifter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [11:0]      src2,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] rs,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic [1:0]         typ_q, typ_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d;
  logic               over_q, over_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d;

  logic [7:0]         amt;
  logic               is_ror, rot32, over_in, accept, load_out, kill;
  logic [CNT_W-1:0]   n_load;
  logic [WIDTH-1:0]   step_val;
  logic               step_c;
  logic               unused_rs;

  assign unused_rs = ^rs[WIDTH-1:8];

  always_comb begin
    amt     = src2[4] ? rs[7:0] : {3'b000, src2[11:7]};
    is_ror  = (src2[6:5] == T_ROR);
    rot32   = is_ror && (amt != 8'd0) && (amt[4:0] == 5'd0);
    over_in = !is_ror && (amt > 8'd32);
    if (is_ror)
      n_load = CNT_W'(amt[4:0]);
    else if (amt > 8'd32)
      n_load = CNT_W'(WIDTH);
    else
      n_load = CNT_W'(amt);
  end

  assign accept = start && (state_q != S_SHIFT);

  always_comb begin
    step_val = val_q;
    step_c   = c_q;
    case (typ_q)
      T_LSL: begin step_val = {val_q[WIDTH-2:0], 1'b0};         step_c = val_q[WIDTH-1]; end
      T_LSR: begin step_val = {1'b0, val_q[WIDTH-1:1]};         step_c = val_q[0];       end
      T_ASR: begin step_val = {val_q[WIDTH-1], val_q[WIDTH-1:1]}; step_c = val_q[0];     end
      T_ROR: begin step_val = {val_q[0], val_q[WIDTH-1:1]};     step_c = val_q[0];       end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    typ_d       = typ_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    over_d      = over_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    load_out    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (accept) begin
          val_d  = rd2;
          typ_d  = src2[6:5];
          cnt_d  = n_load;
          over_d = over_in;
          // A rotate by a nonzero multiple of 32 leaves the value intact but still reports bit 31.
          c_d    = rot32 ? rd2[WIDTH-1] : carry_in;
          if (n_load == '0) begin
            state_d  = S_DONE;
            load_out = 1'b1;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        val_d = step_val;
        c_d   = step_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          load_out = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Logical shifts beyond 32 push every bit (and the carry) out.
    kill = over_d && (typ_d != T_ASR);
    if (load_out) begin
      result_d    = kill ? '0 : val_d;
      carry_out_d = kill ? 1'b0 : c_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      val_q       <= '0;
      typ_q       <= T_LSL;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      over_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      typ_q       <= typ_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      over_q      <= over_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;

endmodule
